// File: rtl/bdd_walk_pkg.sv
// bdd_walk_pkg: shared types, terminal pointers and width helpers for the BDD walk engine.
package bdd_walk_pkg;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int PTR_ZERO = 0;
    localparam int PTR_ONE  = 1;

    localparam int DEF_VAR_W = clog2_min1(1894);
    localparam int DEF_PTR_W = clog2_min1(128);

    // Canonical node word layout at default widths; the engine mirrors it at its own widths.
    typedef struct packed {
        logic [DEF_VAR_W-1:0] var_idx;
        logic [DEF_PTR_W-1:0] hi;
        logic [DEF_PTR_W-1:0] lo;
    } node_t;

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

endpackage

// File: rtl/bdd_node_table.sv
// bdd_node_table: reset-to-zero register array, one write port, one combinational read port.
module bdd_node_table
    import bdd_walk_pkg::*;
#(
    parameter int NODE_DEPTH = 128,
    parameter int NODE_W     = 25,
    localparam int PTR_W     = clog2_min1(NODE_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [NODE_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [NODE_W-1:0] rdata
);
    logic [NODE_W-1:0] mem_q [NODE_DEPTH];
    logic [NODE_W-1:0] mem_d [NODE_DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_q <= '{default: '0};
        else        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/bdd_walk_engine.sv
// bdd_walk_engine: evaluates N_OUT bits of a table-held ROBDD against a latched
// input vector, walking one node per clock with a per-bit step limit.
module bdd_walk_engine
    import bdd_walk_pkg::*;
#(
    parameter int IN_W       = 1894,
    parameter int NODE_DEPTH = 128,
    parameter int N_OUT      = 8,
    localparam int VAR_W     = clog2_min1(IN_W),
    localparam int PTR_W     = clog2_min1(NODE_DEPTH),
    localparam int NODE_W    = VAR_W + 2*PTR_W,
    localparam int K_W       = clog2_min1(N_OUT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [PTR_W-1:0]  cfg_addr,
    input  logic [NODE_W-1:0] cfg_wdata,
    input  logic              root_we,
    input  logic [K_W-1:0]    root_idx,
    input  logic [PTR_W-1:0]  root_ptr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_OUT-1:0]  out_vec,
    output logic              out_err
);
    typedef struct packed {
        logic [VAR_W-1:0] var_idx;
        logic [PTR_W-1:0] hi;
        logic [PTR_W-1:0] lo;
    } node_w_t;

    localparam logic [PTR_W:0]   STEP_LIM = (PTR_W+1)'(NODE_DEPTH);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(N_OUT-1);

    state_t            state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W:0]    step_q, step_d;
    logic [IN_W-1:0]   vec_q, vec_d;
    logic [N_OUT-1:0]  res_q, res_d;
    logic              err_q, err_d;
    logic [PTR_W-1:0]  root_q [N_OUT];
    logic [PTR_W-1:0]  root_d [N_OUT];
    logic [NODE_W-1:0] node_word;
    node_w_t           node;
    logic              var_ok, sel, terminal, tbl_we;

    bdd_node_table #(.NODE_DEPTH(NODE_DEPTH), .NODE_W(NODE_W)) u_table (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (tbl_we),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .raddr (ptr_q),
        .rdata (node_word)
    );

    assign tbl_we    = cfg_we && state_q == IDLE;
    assign node      = node_w_t'(node_word);
    assign var_ok    = 32'(node.var_idx) < IN_W;
    assign sel       = var_ok && vec_q[node.var_idx];
    assign terminal  = ptr_q <= PTR_W'(PTR_ONE);
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign out_vec   = res_q;
    assign out_err   = err_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        ptr_d   = ptr_q;
        step_d  = step_q;
        vec_d   = vec_q;
        res_d   = res_q;
        err_d   = err_q;
        root_d  = root_q;
        case (state_q)
            IDLE: begin
                if (root_we && 32'(root_idx) < N_OUT) root_d[root_idx] = root_ptr;
                // Root written this cycle is visible to a walk accepted this cycle.
                if (in_valid) begin
                    state_d = WALK;
                    vec_d   = in_vec;
                    k_d     = '0;
                    ptr_d   = root_d[0];
                    step_d  = '0;
                    res_d   = '0;
                    err_d   = 1'b0;
                end
            end
            WALK: begin
                if (terminal || step_q == STEP_LIM) begin
                    res_d[k_q] = terminal && ptr_q == PTR_W'(PTR_ONE);
                    err_d      = err_q || !terminal;
                    if (k_q == K_LAST) state_d = DONE;
                    else begin
                        k_d    = k_q + K_W'(1);
                        ptr_d  = root_q[k_q + K_W'(1)];
                        step_d = '0;
                    end
                end else begin
                    ptr_d  = sel ? node.hi : node.lo;
                    step_d = step_q + (PTR_W+1)'(1);
                    err_d  = err_q || !var_ok;
                end
            end
            default: if (out_ready) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            ptr_q   <= PTR_W'(PTR_ZERO);
            step_q  <= '0;
            vec_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            root_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ptr_q   <= ptr_d;
            step_q  <= step_d;
            vec_q   <= vec_d;
            res_q   <= res_d;
            err_q   <= err_d;
            root_q  <= root_d;
        end
    end
endmodule

// File: tb/tb_bdd_walk_engine.sv
// tb_bdd_walk_engine: scoreboard bench with directed cases and randomized tables
// checked against a path-walking reference model.
module tb_bdd_walk_engine;
    localparam int IN_W = 8, DEPTH = 16, NO = 2;

    logic        clk = 0, rst_n = 0;
    logic        cfg_we = 0, root_we = 0, in_valid = 0, out_ready = 1;
    logic [3:0]  cfg_addr = 0, root_ptr = 0;
    logic [10:0] cfg_wdata = 0;
    logic        root_idx = 0;
    logic [7:0]  in_vec = 0;
    logic        in_ready, out_valid, out_err;
    logic [1:0]  out_vec;

    bdd_walk_engine #(.IN_W(IN_W), .NODE_DEPTH(DEPTH), .N_OUT(NO)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .root_we(root_we), .root_idx(root_idx), .root_ptr(root_ptr), .in_valid(in_valid),
        .in_ready(in_ready), .in_vec(in_vec), .out_valid(out_valid), .out_ready(out_ready),
        .out_vec(out_vec), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] v; logic e; int lat; int acc; } exp_t;
    exp_t sbq[$];
    int   cyc = 0, n_cmp = 0, n_bad = 0, rise = 0;
    logic prev_v = 0, rand_rdy = 0;
    int   m_var[DEPTH], m_hi[DEPTH], m_lo[DEPTH], m_root[NO];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) prev_v = 0;
        else begin
            if (out_valid && !prev_v) rise = cyc;
            prev_v = out_valid;
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) chk("unexpected_out", 1, 0);
                else begin
                    e = sbq.pop_front();
                    chk("out_vec", 32'(out_vec), 32'(e.v));
                    chk("out_err", 32'(out_err), 32'(e.e));
                    chk("latency", 32'(rise - e.acc), 32'(e.lat));
                end
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rand_rdy) out_ready = $urandom_range(0, 2) != 0;
    end

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin m_var[i] = 0; m_hi[i] = 0; m_lo[i] = 0; end
        for (int i = 0; i < NO; i++) m_root[i] = 0;
    endtask

    task automatic model_eval(input logic [7:0] v, output logic [1:0] ov, output logic oe, output int lat);
        ov = 0; oe = 0; lat = 0;
        for (int b = 0; b < NO; b++) begin
            int p = m_root[b], s = 0;
            while (p >= 2 && s < DEPTH) begin
                p = (m_var[p] < IN_W && v[m_var[p]]) ? m_hi[p] : m_lo[p];
                s++;
            end
            lat += s + 1;
            if (p >= 2) oe = 1;
            else ov[b] = (p == 1);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 500) begin @(posedge clk); #1; n++; end
        if (!in_ready) chk("idle_timeout", 32'(in_ready), 1);
    endtask

    task automatic set_node(input int a, input int vr, input int hi, input int lo);
        cfg_we = 1; cfg_addr = 4'(a); cfg_wdata = {3'(vr), 4'(hi), 4'(lo)};
        m_var[a] = vr; m_hi[a] = hi; m_lo[a] = lo;
    endtask

    task automatic set_root(input int b, input int p);
        root_we = 1; root_idx = 1'(b); root_ptr = 4'(p); m_root[b] = p;
    endtask

    task automatic wr_node(input int a, input int vr, input int hi, input int lo);
        wait_idle(); set_node(a, vr, hi, lo);
        @(posedge clk); #1; cfg_we = 0;
    endtask

    task automatic wr_root(input int b, input int p);
        wait_idle(); set_root(b, p);
        @(posedge clk); #1; root_we = 0;
    endtask

    task automatic issue(input logic [7:0] v, input logic use_model, input logic [1:0] dv, input logic de, input int dl);
        exp_t e;
        wait_idle();
        if (use_model) begin
            if ($urandom_range(0, 3) == 0) set_node($urandom_range(2, 15), $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) set_root($urandom_range(0, 1), $urandom_range(0, 15));
        end
        in_valid = 1; in_vec = v;
        if (use_model) model_eval(v, e.v, e.e, e.lat);
        else begin e.v = dv; e.e = de; e.lat = dl; end
        @(posedge clk); #1;
        in_valid = 0; cfg_we = 0; root_we = 0;
        e.acc = cyc;
        sbq.push_back(e);
    endtask

    initial begin
        int n;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_vec", 32'(out_vec), 0);
        chk("rst_out_err", 32'(out_err), 0);

        issue(8'hFF, 0, 2'b00, 0, 2);
        wr_node(2, 3, 1, 0); wr_root(0, 2); wr_root(1, 1);
        issue(8'h08, 0, 2'b11, 0, 3);
        issue(8'h00, 0, 2'b10, 0, 3);
        wr_node(2, 1, 0, 3); wr_node(3, 2, 0, 4); wr_node(4, 0, 0, 1);
        issue(8'h00, 0, 2'b11, 0, 5);
        issue(8'h04, 0, 2'b10, 0, 4);
        wr_node(5, 0, 5, 5); wr_root(0, 5);
        issue(8'h00, 0, 2'b10, 1, 18);

        wait_idle();
        out_ready = 0;
        issue(8'h00, 0, 2'b10, 1, 18);
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk("done_reached", 32'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_vec = 8'hFF;
            if (i == 2) begin cfg_we = 1; cfg_addr = 4'd5; cfg_wdata = {3'd0, 4'd1, 4'd1}; end
            @(posedge clk); #1;
            cfg_we = 0;
            chk("hold_vec", 32'(out_vec), 2);
            chk("hold_err", 32'(out_err), 1);
            chk("hold_busy", 32'(in_ready), 0);
        end
        in_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        chk("ready_back", 32'(in_ready), 1);
        issue(8'h00, 0, 2'b10, 1, 18);

        wait_idle();
        in_valid = 1; in_vec = 8'h00;
        @(posedge clk); #1 in_valid = 0;
        repeat (4) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_ready", 32'(in_ready), 1);
        chk("midrst_vec", 32'(out_vec), 0);
        @(posedge clk); #1 rst_n = 1;
        model_clear();
        wr_root(0, 2);
        issue(8'h08, 0, 2'b00, 0, 3);

        rand_rdy = 1;
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 2) == 0) wr_node($urandom_range(2, 15), $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) wr_root($urandom_range(0, 1), $urandom_range(0, 15));
            issue(8'($urandom), 1, 2'b00, 0, 0);
        end
        rand_rdy = 0;
        out_ready = 1;
        n = 0;
        while (sbq.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
        chk("drain", 32'(sbq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bdd_walk_engine.md
# bdd_walk_engine

Programmable, multi-output successor to the generated per-bit BDD output modules. It holds a reduced ordered BDD as a node table instead of fixed logic. It evaluates N_OUT output bits against a latched wide input vector by walking one node per clock. It sits beside the per-bit modules in the CPU output cluster, so that bit functions can be reloaded at run time and output bits can share nodes.

## Interface
- IN_W, default 1894: input vector width.
- NODE_DEPTH, default 128: node-table entries; power of two, at least 4.
- N_OUT, default 8: output bits evaluated per request.
- Derived: VAR_W = $clog2(IN_W), PTR_W = $clog2(NODE_DEPTH), NODE_W = VAR_W + 2*PTR_W.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  node-table write strobe.
- cfg_addr  in  PTR_W  node index written.
- cfg_wdata  in  NODE_W  node word, packed {var, hi, lo}.
- root_we  in  1  root-pointer write strobe.
- root_idx  in  $clog2(N_OUT) (min 1)  output bit whose root is written.
- root_ptr  in  PTR_W  root node for that bit.
- in_valid  in  1  request valid.
- in_ready  out  1  engine can accept a request.
- in_vec  in  IN_W  input vector.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed.
- out_vec  out  N_OUT  evaluated bits.
- out_err  out  1  at least one bit hit the step limit or had an out-of-range variable.

## Operation
- Pointer values 0 and 1 are the terminals constant-0 and constant-1. Table entries 0 and 1 are never read.
- States:
  - IDLE: in_ready = 1.
  - WALK: in_ready = 0.
  - DONE: out_valid = 1.
- IDLE → WALK on in_valid && in_ready.
  - in_vec is latched.
  - k = 0, ptr = root[0], step = 0, result and error accumulator cleared.
- One WALK cycle:
  - If ptr < 2: commit bit k = ptr[0]; then either k++, ptr = root[k+1], step = 0, or, if k == N_OUT-1, go to DONE.
  - Otherwise: read node[ptr]; ptr = vec[var] ? hi : lo; step++.
  - If var >= IN_W, the variable value is taken as 0 and the error accumulator is set.
- Step limit: when step == NODE_DEPTH and ptr is still non-terminal, bit k is committed as 0, the error accumulator is set, and the walk continues with the next bit. This bounds cyclic tables.
- DONE: out_vec and out_err are driven from the accumulators and held stable. DONE → IDLE on out_ready.
- cfg_we and root_we are honoured only in IDLE. In WALK or DONE they are silently dropped, so the table stays coherent for the walk in progress.
- A config write and an accepted request in the same IDLE cycle: the write lands; the walk starts next cycle and sees the new value.

## Timing
- Reset values:
  - State IDLE; in_ready = 1; out_valid = 0, out_vec = 0, out_err = 0.
  - All roots = 0. All node words = 0, which are terminal-safe.
- Cost of bit k = (non-terminal nodes on its path) + 1 cycles.
- Latency: from the accepting edge to out_valid = sum of bit costs, with out_valid high the cycle after the last commit.
- Minimum latency is N_OUT cycles (all roots terminal). Maximum is N_OUT*(NODE_DEPTH+1).
- out_valid deasserts on the edge where out_valid && out_ready. in_ready reasserts on that same edge, so back-to-back throughput has one IDLE cycle.
- Node read is combinational from the register table; the next-pointer mux is the critical path (PTR_W-bit).
- rst_n assertion mid-WALK or mid-DONE: immediate return to reset values; the partial result is discarded.

## Structure
- Package bdd_walk_pkg holds:
  - the node_t packed struct {var, hi, lo};
  - the terminal constants PTR_ZERO = 0 and PTR_ONE = 1;
  - the state enum {IDLE, WALK, DONE};
  - width-derivation functions.
- Sub-module bdd_node_table holds the reset-to-zero register array with one write port and one combinational read port, parameterised on NODE_DEPTH and NODE_W.
- bdd_walk_engine holds the FSM, root registers, latched vector, step counter and accumulators.

## Test plan
All scenarios use IN_W=8, NODE_DEPTH=16, N_OUT=2.
- Reset, no config; in_vec = 8'hFF → out_vec = 2'b00, out_err = 0, out_valid two cycles after the accepting edge.
- node[2] = {3, 1, 0}, root0 = 2, root1 = 1:
  - in_vec = 8'h08 → out_vec = 2'b11;
  - in_vec = 8'h00 → out_vec = 2'b10; 3-cycle latency.
- Chain computing !v1 & !v2 & !v0:
  - node[2] = {1, 0, 3}, node[3] = {2, 0, 4}, node[4] = {0, 0, 1}, root0 = 2.
  - in_vec = 8'h00 → bit0 = 1 after 4 cycles; in_vec = 8'h04 → bit0 = 0.
- Self-loop node[5] = {0, 5, 5}, root0 = 5 → bit0 = 0 and out_err = 1 after 17 cycles; bit1 is still evaluated correctly.
- Hold out_ready low 5 cycles in DONE → out_vec stable, in_ready = 0, a second in_valid is not accepted, and a cfg_we pulse leaves the node unchanged.
- Pulse rst_n low during WALK → out_valid = 0, in_ready = 1, the previously written node[2] reads back as 0.
